// File: rtl/floor_request_register_if.sv
// ---------------------------------------------------------------------------
// floor_request_register_if
//
// Bundles the floor-request datapath signals between the button/position
// sources, the floor_request_register block and the downstream direction
// logic.
//
// Parameters:
//   FLOORS        number of floors; width of every floor vector
//
// Signals:
//   floorbutton   synchronized floor-button levels, bit i = floor i
//   currentFloor  one-hot car position from floorControl
//   direction     car motion: 2'b10 up, 2'b01 down, 2'b00 stopped,
//                 2'b11 treated as moving
//   nextFloor     pending requests presented to the direction block
//   doorOpen      high while the door dwell is running
//   pending       saturating population count of pending requests
//
// Modports:
//   master        drives buttons/position/motion, observes the outputs
//   slave         the floor_request_register block itself
// ---------------------------------------------------------------------------
interface floor_request_register_if #(
  parameter int FLOORS = 6
);
  logic [FLOORS-1:0] floorbutton;
  logic [FLOORS-1:0] currentFloor;
  logic [1:0]        direction;
  logic [FLOORS-1:0] nextFloor;
  logic              doorOpen;
  logic [2:0]        pending;

  modport master (
    output floorbutton,
    output currentFloor,
    output direction,
    input  nextFloor,
    input  doorOpen,
    input  pending
  );

  modport slave (
    input  floorbutton,
    input  currentFloor,
    input  direction,
    output nextFloor,
    output doorOpen,
    output pending
  );
endinterface

// File: rtl/floor_request_register.sv
// ---------------------------------------------------------------------------
// floor_request_register
//
// Upstream stage of the elevator datapath. Rising edges on the synchronized
// floor buttons latch pending requests; when the car is stopped at a floor
// with a pending request, that request is cleared and the door is held open
// for DWELL clock cycles. Pending requests are presented on nextFloor
// (blanked while the door is open) together with a saturating count.
//
// Parameters:
//   FLOORS   number of floors (default 6)
//   DWELL    door-open time in clk cycles, legal range 1..15 (default 3)
//
// Ports:
//   clk      divided system clock, all state updates on its rising edge
//   reset    synchronous, active-high
//   bus      floor_request_register_if.slave
//              in : floorbutton, currentFloor, direction
//              out: nextFloor, doorOpen, pending (all registered)
//
// Build option:
//   REQ_CANCEL_EN  when defined, pressing a floor whose request is already
//                  pending (outside the door dwell) cancels that request.
//                  When undefined such presses are ignored.
// ---------------------------------------------------------------------------
module floor_request_register #(
  parameter int FLOORS = 6,
  parameter int DWELL  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  floor_request_register_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,   // no pending requests
    SERVE = 2'd1,   // requests pending, waiting for the car to stop at one
    DOOR  = 2'd2    // door dwell running
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

  state_t            state_q, state_d;
  logic [FLOORS-1:0] prev_q;
  logic [FLOORS-1:0] req_q, req_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              door_q, door_d;
  logic [FLOORS-1:0] next_floor_q, next_floor_d;
  logic [2:0]        pending_q, pending_d;

  logic [FLOORS-1:0] press;
  logic [FLOORS-1:0] cur_floor;
  logic              cur_one_hot;
  logic              hit;
  logic              restart;

  function automatic int unsigned popcount(input logic [FLOORS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < FLOORS; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Only a rising edge of a button counts; a held button sets its bit once.
  assign press     = bus.floorbutton & ~prev_q;
  assign cur_floor = bus.currentFloor;

  // A position vector that is zero or has several bits set is a glitch from
  // floorControl and must never clear a request.
  assign cur_one_hot = (popcount(cur_floor) == 1);

  assign hit = cur_one_hot
            && (bus.direction == 2'b00)
            && ((cur_floor & req_q) != '0);

  // Re-pressing the button of the floor the car is parked at keeps the door
  // open instead of queueing a request.
  assign restart = ((press & cur_floor) != '0);

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    door_d  = door_q;

    unique case (state_q)
      IDLE: begin
        req_d = req_q | press;
        if (req_d != '0) state_d = SERVE;
      end

      SERVE: begin
`ifdef REQ_CANCEL_EN
        // A press on an idle floor sets its bit, on a pending floor clears it.
        req_d = req_q ^ press;
`else
        req_d = req_q | press;
`endif
        if (hit) begin
          // Applied after the press so a same-cycle press at this floor
          // cannot resurrect the request being served.
          req_d   = req_d & ~cur_floor;
          door_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = DOOR;
        end else if (req_d == '0) begin
          state_d = IDLE;
        end
      end

      DOOR: begin
        req_d = req_q | (press & ~cur_floor);
        if (restart) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == 4'd0) begin
          door_d  = 1'b0;
          state_d = (req_d != '0) ? SERVE : IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are computed from registered state only, so no input reaches an
  // output without passing through a flop.
  always_comb begin
    int unsigned n;
    n            = popcount(req_q);
    pending_d    = (n > 7) ? 3'd7 : 3'(n);
    next_floor_d = door_q ? '0 : req_q;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement
    // order.
    // The edge detector keeps tracking the buttons through reset, so a
    // button held across reset is not seen as a fresh press afterwards.
    prev_q <= bus.floorbutton;
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= 4'd0;
      door_q       <= 1'b0;
      next_floor_q <= '0;
      pending_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      door_q       <= door_d;
      next_floor_q <= next_floor_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.nextFloor = next_floor_q;
  assign bus.doorOpen  = door_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_floor_request_register.sv
// ---------------------------------------------------------------------------
// tb_floor_request_register
//
// Directed bench for floor_request_register (FLOORS = 6, DWELL = 3). Each
// step drives one set of inputs, pushes the outputs expected after the next
// rising edge onto a scoreboard queue, and pops/compares them #1 after that
// edge.
// ---------------------------------------------------------------------------
module tb_floor_request_register;

  localparam int FLOORS = 6;
  localparam int DWELL  = 3;

  localparam logic [1:0] STOP = 2'b00;
  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] BOTH = 2'b11;

  logic clk;
  logic reset;

  floor_request_register_if #(.FLOORS(FLOORS)) bus ();

  floor_request_register #(
    .FLOORS (FLOORS),
    .DWELL  (DWELL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [5:0]  next_floor;
    logic        door_open;
    logic [2:0]  pending;
  } exp_t;

  exp_t sb[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".nextFloor"}, 32'(bus.nextFloor), 32'(e.next_floor));
    check({e.tag, ".doorOpen"},  32'(bus.doorOpen),  32'(e.door_open));
    check({e.tag, ".pending"},   32'(bus.pending),   32'(e.pending));
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input string tag, input logic rst,
                      input logic [5:0] fb, input logic [5:0] cf,
                      input logic [1:0] dir, input logic [5:0] exp_nf,
                      input logic exp_door, input logic [2:0] exp_pend);
    exp_t e;
    reset            = rst;
    bus.floorbutton  = fb;
    bus.currentFloor = cf;
    bus.direction    = dir;
    e.tag        = tag;
    e.next_floor = exp_nf;
    e.door_open  = exp_door;
    e.pending    = exp_pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic do_reset(input string tag);
    step({tag, "_rst0"}, 1'b1, 6'b0, 6'b0, STOP, 6'b0, 1'b0, 3'd0);
    step({tag, "_rst1"}, 1'b1, 6'b0, 6'b0, STOP, 6'b0, 1'b0, 3'd0);
  endtask

  // Watchdog: the bench is clocked by itself, but never let it hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    bus.floorbutton  = '0;
    bus.currentFloor = '0;
    bus.direction    = STOP;
    @(posedge clk);
    #1;

    // Button held through reset is not a press; a fresh edge is.
    step("held_rst0", 1'b1, 6'b000100, 6'b0, STOP, 6'b0, 1'b0, 3'd0);
    step("held_rst1", 1'b1, 6'b000100, 6'b0, STOP, 6'b0, 1'b0, 3'd0);
    step("held_rel0", 1'b0, 6'b000100, 6'b0, STOP, 6'b0, 1'b0, 3'd0);
    step("held_rel1", 1'b0, 6'b000100, 6'b0, STOP, 6'b0, 1'b0, 3'd0);
    step("held_low",  1'b0, 6'b000000, 6'b0, STOP, 6'b0, 1'b0, 3'd0);
    step("held_high", 1'b0, 6'b000100, 6'b0, STOP, 6'b0, 1'b0, 3'd0);
    step("held_vis",  1'b0, 6'b000100, 6'b0, STOP, 6'b000100, 1'b0, 3'd1);
    step("held_keep", 1'b0, 6'b000100, 6'b0, STOP, 6'b000100, 1'b0, 3'd1);

    // Serve floor 5: door open exactly DWELL cycles, then idle.
    do_reset("f5");
    step("f5_press", 1'b0, 6'b100000, 6'b0,      STOP, 6'b0,      1'b0, 3'd0);
    step("f5_vis",   1'b0, 6'b100000, 6'b0,      STOP, 6'b100000, 1'b0, 3'd1);
    step("f5_hit",   1'b0, 6'b000000, 6'b100000, STOP, 6'b100000, 1'b1, 3'd1);
    step("f5_dw2",   1'b0, 6'b000000, 6'b100000, STOP, 6'b0,      1'b1, 3'd0);
    step("f5_dw3",   1'b0, 6'b000000, 6'b100000, STOP, 6'b0,      1'b1, 3'd0);
    step("f5_close", 1'b0, 6'b000000, 6'b100000, STOP, 6'b0,      1'b0, 3'd0);
    step("f5_idle",  1'b0, 6'b000000, 6'b100000, STOP, 6'b0,      1'b0, 3'd0);

    // Floors 0 and 4 together, stop at 4.
    do_reset("f04");
    step("f04_press", 1'b0, 6'b010001, 6'b0,      STOP, 6'b0,      1'b0, 3'd0);
    step("f04_vis",   1'b0, 6'b010001, 6'b0,      STOP, 6'b010001, 1'b0, 3'd2);
    step("f04_hit",   1'b0, 6'b000000, 6'b010000, STOP, 6'b010001, 1'b1, 3'd2);
    step("f04_dw2",   1'b0, 6'b000000, 6'b010000, STOP, 6'b0,      1'b1, 3'd1);
    step("f04_dw3",   1'b0, 6'b000000, 6'b010000, STOP, 6'b0,      1'b1, 3'd1);
    step("f04_close", 1'b0, 6'b000000, 6'b010000, STOP, 6'b0,      1'b0, 3'd1);
    step("f04_rest",  1'b0, 6'b000000, 6'b010000, STOP, 6'b000001, 1'b0, 3'd1);

    // Re-press floor 2 in dwell cycle 2: dwell restarts, request not latched.
    do_reset("rp");
    step("rp_press",   1'b0, 6'b000100, 6'b0,      STOP, 6'b0,      1'b0, 3'd0);
    step("rp_vis",     1'b0, 6'b000100, 6'b0,      STOP, 6'b000100, 1'b0, 3'd1);
    step("rp_hit",     1'b0, 6'b000000, 6'b000100, STOP, 6'b000100, 1'b1, 3'd1);
    step("rp_dw2",     1'b0, 6'b000000, 6'b000100, STOP, 6'b0,      1'b1, 3'd0);
    step("rp_repress", 1'b0, 6'b000100, 6'b000100, STOP, 6'b0,      1'b1, 3'd0);
    step("rp_dw4",     1'b0, 6'b000100, 6'b000100, STOP, 6'b0,      1'b1, 3'd0);
    step("rp_dw5",     1'b0, 6'b000000, 6'b000100, STOP, 6'b0,      1'b1, 3'd0);
    step("rp_close",   1'b0, 6'b000000, 6'b000100, STOP, 6'b0,      1'b0, 3'd0);
    step("rp_clear",   1'b0, 6'b000000, 6'b000100, STOP, 6'b0,      1'b0, 3'd0);

    // Invalid position and moving car never clear; a valid stop does.
    do_reset("inv");
    step("inv_press", 1'b0, 6'b000110, 6'b0,      STOP, 6'b0,      1'b0, 3'd0);
    step("inv_vis",   1'b0, 6'b000110, 6'b0,      STOP, 6'b000110, 1'b0, 3'd2);
    step("inv_two",   1'b0, 6'b000110, 6'b000110, STOP, 6'b000110, 1'b0, 3'd2);
    step("inv_two2",  1'b0, 6'b000110, 6'b000110, STOP, 6'b000110, 1'b0, 3'd2);
    step("inv_zero",  1'b0, 6'b000110, 6'b000000, STOP, 6'b000110, 1'b0, 3'd2);
    step("inv_up",    1'b0, 6'b000110, 6'b000010, UP,   6'b000110, 1'b0, 3'd2);
    step("inv_both",  1'b0, 6'b000110, 6'b000010, BOTH, 6'b000110, 1'b0, 3'd2);
    step("inv_stop",  1'b0, 6'b000110, 6'b000010, STOP, 6'b000110, 1'b1, 3'd2);
    step("inv_dw2",   1'b0, 6'b000110, 6'b000010, STOP, 6'b0,      1'b1, 3'd1);

    // Press and hit on the same floor in the same cycle: clear wins.
    do_reset("sim");
    step("sim_press", 1'b0, 6'b001000, 6'b0,      STOP, 6'b0,      1'b0, 3'd0);
    step("sim_vis",   1'b0, 6'b000000, 6'b0,      STOP, 6'b001000, 1'b0, 3'd1);
    step("sim_hit",   1'b0, 6'b001000, 6'b001000, STOP, 6'b001000, 1'b1, 3'd1);
    step("sim_dw2",   1'b0, 6'b001000, 6'b001000, STOP, 6'b0,      1'b1, 3'd0);

    // Press at another floor during the dwell: latched, hidden until close.
    do_reset("oth");
    step("oth_press", 1'b0, 6'b001000, 6'b0,      STOP, 6'b0,      1'b0, 3'd0);
    step("oth_vis",   1'b0, 6'b000000, 6'b0,      STOP, 6'b001000, 1'b0, 3'd1);
    step("oth_hit",   1'b0, 6'b000000, 6'b001000, STOP, 6'b001000, 1'b1, 3'd1);
    step("oth_p0",    1'b0, 6'b000001, 6'b001000, STOP, 6'b0,      1'b1, 3'd0);
    step("oth_dw3",   1'b0, 6'b000000, 6'b001000, STOP, 6'b0,      1'b1, 3'd1);
    step("oth_close", 1'b0, 6'b000000, 6'b001000, STOP, 6'b0,      1'b0, 3'd1);
    step("oth_rest",  1'b0, 6'b000000, 6'b001000, STOP, 6'b000001, 1'b0, 3'd1);

    // Reset mid-dwell: door closes, requests drop, no residual dwell.
    do_reset("rmd");
    step("rmd_press", 1'b0, 6'b100001, 6'b0,      STOP, 6'b0,      1'b0, 3'd0);
    step("rmd_vis",   1'b0, 6'b000000, 6'b0,      STOP, 6'b100001, 1'b0, 3'd2);
    step("rmd_hit",   1'b0, 6'b000000, 6'b100000, STOP, 6'b100001, 1'b1, 3'd2);
    step("rmd_rst",   1'b1, 6'b000000, 6'b100000, STOP, 6'b0,      1'b0, 3'd0);
    step("rmd_after", 1'b0, 6'b000000, 6'b100000, STOP, 6'b0,      1'b0, 3'd0);
    step("rmd_after2",1'b0, 6'b000000, 6'b100000, STOP, 6'b0,      1'b0, 3'd0);

    // All floors at once.
    do_reset("all");
    step("all_press", 1'b0, 6'b111111, 6'b0, STOP, 6'b0,      1'b0, 3'd0);
    step("all_vis",   1'b0, 6'b000000, 6'b0, STOP, 6'b111111, 1'b0, 3'd6);

    // Second press on an already pending floor.
    do_reset("dup");
    step("dup_press1", 1'b0, 6'b000010, 6'b0, STOP, 6'b0,      1'b0, 3'd0);
    step("dup_low",    1'b0, 6'b000000, 6'b0, STOP, 6'b000010, 1'b0, 3'd1);
    step("dup_press2", 1'b0, 6'b000010, 6'b0, STOP, 6'b000010, 1'b0, 3'd1);
`ifdef REQ_CANCEL_EN
    step("dup_result", 1'b0, 6'b000000, 6'b0, STOP, 6'b000000, 1'b0, 3'd0);
`else
    step("dup_result", 1'b0, 6'b000000, 6'b0, STOP, 6'b000010, 1'b0, 3'd1);
`endif

    if (sb.size() != 0) check("scoreboard_leftover", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
